// File: rtl/f1_light_seq.sv
// ============================================================================
// f1_light_seq
// ----------------------------------------------------------------------------
// F1 start-light sequencer. A rising edge on trigger starts a run. The lamps
// light one per tick from the LSB up. When all lamps are lit they stay lit for
// a hold period. Then every lamp goes out and lights_out pulses for one cycle
// to start the downstream reaction timer.
//
// Optional feature (compile-time macro RANDOM_DELAY_EN):
//   defined   : hold length = HOLD_MIN + lfsr[RAND_BITS-1:0]. The value is
//               sampled on the FILL->HOLD cycle from a free-running 7-bit
//               Fibonacci LFSR (x^7 + x^6 + 1).
//   undefined : hold length = HOLD_MIN. No LFSR is built.
//
// Parameters:
//   N_LIGHTS   number of lamps (2..16)
//   HOLD_MIN   minimum hold length in ticks (>= 1)
//   RAND_BITS  LFSR bits added to HOLD_MIN when randomised (1..7)
//   SEED       LFSR reset value (non-zero)
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   tick enable; FILL/HOLD advance only when en=1
//   trigger    in   start request (level); its rising edge is detected inside
//   abort      in   synchronous cancel; returns to IDLE with no pulses
//   data_out   out  lamp vector, LSB = first lamp (registered)
//   cmd_seq    out  high while a run is active, FILL or HOLD (registered)
//   cmd_delay  out  one-cycle pulse on entry to HOLD (registered)
//   lights_out out  one-cycle pulse when the lamps go out after HOLD
//                   (registered; never pulses on abort or reset)
// ============================================================================
module f1_light_seq #(
    parameter int         N_LIGHTS  = 8,
    parameter int         HOLD_MIN  = 2,
    parameter int         RAND_BITS = 4,
    parameter logic [6:0] SEED      = 7'h01
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                trigger,
    input  logic                abort,
    output logic [N_LIGHTS-1:0] data_out,
    output logic                cmd_seq,
    output logic                cmd_delay,
    output logic                lights_out
);

    // The hold counter is sized for the largest possible hold length, so
    // loading it can never wrap.
    localparam int CNT_W = $clog2(HOLD_MIN + 2**RAND_BITS) + 1;

    localparam logic [N_LIGHTS-1:0] ALL_ONES   = {N_LIGHTS{1'b1}};
    localparam logic [N_LIGHTS-1:0] ALL_ZEROS  = {N_LIGHTS{1'b0}};
    localparam logic [N_LIGHTS-1:0] FIRST_LAMP = {{(N_LIGHTS-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    HOLD_BASE  = CNT_W'(HOLD_MIN);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------------
    if ((N_LIGHTS < 2) || (N_LIGHTS > 16)) begin : g_bad_n_lights
        $error("f1_light_seq: N_LIGHTS=%0d outside 2..16", N_LIGHTS);
    end
    if ((RAND_BITS < 1) || (RAND_BITS > 7)) begin : g_bad_rand_bits
        $error("f1_light_seq: RAND_BITS=%0d outside 1..7", RAND_BITS);
    end
    if (HOLD_MIN < 1) begin : g_bad_hold_min
        $error("f1_light_seq: HOLD_MIN=%0d must be >= 1", HOLD_MIN);
    end
    if (SEED == 7'h00) begin : g_bad_seed
        $error("f1_light_seq: SEED must be non-zero");
    end

    // ------------------------------------------------------------------------
    // State encoding. The unused code 2'b11 is sent back to IDLE.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 trig_q_r;
    logic                 trig_rise_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic [CNT_W-1:0]     hold_len_s;
    logic [N_LIGHTS-1:0]  data_nxt_s;
    logic                 cmd_seq_nxt_s;
    logic                 cmd_delay_nxt_s;
    logic                 lights_out_nxt_s;

    // Edge detection runs every cycle and does not depend on en, so a rise
    // that arrives during a frozen tick period is still seen (and ignored).
    assign trig_rise_s = trigger & ~trig_q_r;

`ifdef RANDOM_DELAY_EN
    // ------------------------------------------------------------------------
    // Free-running hold-length randomiser
    // ------------------------------------------------------------------------
    logic [6:0] lfsr_r;

    // Advances a 7-bit Fibonacci LFSR with taps x^7 + x^6 + 1 by one step.
    function automatic logic [6:0] lfsr_next(input logic [6:0] cur);
        return {cur[5:0], cur[6] ^ cur[5]};
    endfunction

    // LFSR advances on every clock and ignores en, so the hold length also
    // depends on how long the tick source stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign hold_len_s = HOLD_BASE + CNT_W'(lfsr_r[RAND_BITS-1:0]);
`else
    assign hold_len_s = HOLD_BASE;
`endif

    // ------------------------------------------------------------------------
    // State register: sequencer state, lamp vector, hold counter, trigger
    // history and the registered command outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            data_out   <= ALL_ZEROS;
            cnt_r      <= CNT_ZERO;
            trig_q_r   <= 1'b0;
            cmd_seq    <= 1'b0;
            cmd_delay  <= 1'b0;
            lights_out <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            data_out   <= data_nxt_s;
            cnt_r      <= cnt_nxt_s;
            trig_q_r   <= trigger;
            cmd_seq    <= cmd_seq_nxt_s;
            cmd_delay  <= cmd_delay_nxt_s;
            lights_out <= lights_out_nxt_s;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Abort has top priority. A new trigger is accepted in
    // IDLE whatever en is. FILL and HOLD move only on ticks.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = data_out;
        cnt_nxt_s   = cnt_r;

        if (abort) begin
            state_nxt_s = ST_IDLE;
            data_nxt_s  = ALL_ZEROS;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_nxt_s = CNT_ZERO;
                    if (trig_rise_s) begin
                        state_nxt_s = ST_FILL;
                        data_nxt_s  = FIRST_LAMP;
                    end else begin
                        data_nxt_s  = ALL_ZEROS;
                    end
                end

                ST_FILL: begin
                    if (en) begin
                        if (data_out == ALL_ONES) begin
                            // Lamps stay fully lit. The hold length is taken
                            // at this moment.
                            state_nxt_s = ST_HOLD;
                            cnt_nxt_s   = hold_len_s;
                        end else begin
                            data_nxt_s  = {data_out[N_LIGHTS-2:0], 1'b1};
                        end
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end

                ST_HOLD: begin
                    if (en) begin
                        if (cnt_r == CNT_ONE) begin
                            state_nxt_s = ST_IDLE;
                            data_nxt_s  = ALL_ZEROS;
                            cnt_nxt_s   = CNT_ZERO;
                        end else begin
                            cnt_nxt_s   = cnt_r - CNT_ONE;
                        end
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end

                default: begin
                    state_nxt_s = ST_IDLE;
                    data_nxt_s  = ALL_ZEROS;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic. It decodes the transition being taken so that the
    // registered pulses line up with the state change.
    // ------------------------------------------------------------------------
    always_comb begin
        cmd_seq_nxt_s    = 1'b0;
        cmd_delay_nxt_s  = 1'b0;
        lights_out_nxt_s = 1'b0;

        if ((state_nxt_s == ST_FILL) || (state_nxt_s == ST_HOLD)) begin
            cmd_seq_nxt_s = 1'b1;
        end else begin
            cmd_seq_nxt_s = 1'b0;
        end

        if ((state_r == ST_FILL) && (state_nxt_s == ST_HOLD)) begin
            cmd_delay_nxt_s = 1'b1;
        end else begin
            cmd_delay_nxt_s = 1'b0;
        end

        // An abort out of HOLD must not look like a completed hold.
        if ((state_r == ST_HOLD) && (state_nxt_s == ST_IDLE) && !abort) begin
            lights_out_nxt_s = 1'b1;
        end else begin
            lights_out_nxt_s = 1'b0;
        end
    end

endmodule

// File: tb/tb_f1_light_seq.sv
// ============================================================================
// tb_f1_light_seq
// ----------------------------------------------------------------------------
// Scoreboard bench for f1_light_seq (N_LIGHTS=8, HOLD_MIN=2, RAND_BITS=4,
// SEED=7'h01). Before each stimulus cycle the bench queues the expected
// registered outputs for that cycle. It pops and compares them 1 ns after the
// rising edge. When RANDOM_DELAY_EN is defined, the hold length comes from a
// reference LFSR that runs next to the DUT.
// ============================================================================
module tb_f1_light_seq;

    localparam int N  = 8;
    localparam int HM = 2;
    localparam int RB = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         trigger;
    logic         abort;
    logic [N-1:0] data_out;
    logic         cmd_seq;
    logic         cmd_delay;
    logic         lights_out;

    typedef struct packed {
        logic [N-1:0] d;
        logic         seq;
        logic         dly;
        logic         lo;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    f1_light_seq #(
        .N_LIGHTS  (N),
        .HOLD_MIN  (HM),
        .RAND_BITS (RB),
        .SEED      (7'h01)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .trigger    (trigger),
        .abort      (abort),
        .data_out   (data_out),
        .cmd_seq    (cmd_seq),
        .cmd_delay  (cmd_delay),
        .lights_out (lights_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RANDOM_DELAY_EN
    // Reference LFSR: x^7 + x^6 + 1, steps every clock, SEED on reset.
    logic [6:0] ref_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_lfsr <= 7'h01;
        else        ref_lfsr <= {ref_lfsr[5:0], ref_lfsr[6] ^ ref_lfsr[5]};
    end
`endif

    // Hold length of a run whose FILL->HOLD edge lies 'off' edges after the
    // next rising edge.
    function automatic int cur_d(input int off);
`ifdef RANDOM_DELAY_EN
        logic [6:0] v;
        v = ref_lfsr;
        for (int k = 0; k < off; k++) v = {v[5:0], v[6] ^ v[5]};
        return HM + int'(v[RB-1:0]);
`else
        return HM + 0 * off;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected outputs after edge i of a run triggered at edge 0 with hold D.
    function automatic exp_t run_rec(input int i, input int d);
        exp_t        r;
        logic [15:0] m;
        r = '0;
        if (i < N) begin
            m     = (16'd1 << (i + 1)) - 16'd1;
            r.d   = m[N-1:0];
            r.seq = 1'b1;
        end else if (i == N) begin
            r.d = '1; r.seq = 1'b1; r.dly = 1'b1;
        end else if (i < N + d) begin
            r.d = '1; r.seq = 1'b1;
        end else begin
            r.lo = 1'b1;
        end
        return r;
    endfunction

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) sbq.push_back(exp_t'(0));
    endtask

    // Drives one cycle of inputs, then compares against the scoreboard head.
    task automatic cyc(input logic t, input logic e, input logic a, input string tag);
        exp_t x;
        trigger = t; en = e; abort = a;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check_eq({tag, ".sb_underflow"}, 32'(sbq.size()), 32'd1);
        end else begin
            x = sbq.pop_front();
            check_eq({tag, ".data"},       32'(data_out),   32'(x.d));
            check_eq({tag, ".cmd_seq"},    32'(cmd_seq),    32'(x.seq));
            check_eq({tag, ".cmd_delay"},  32'(cmd_delay),  32'(x.dly));
            check_eq({tag, ".lights_out"}, 32'(lights_out), 32'(x.lo));
        end
    endtask

    // One full run: trigger pulse on edge 0, then N + d more cycles.
    task automatic do_run(input string tag);
        int d;
        d = cur_d(N);
        for (int i = 0; i <= N + d; i++) sbq.push_back(run_rec(i, d));
        cyc(1'b1, 1'b1, 1'b0, tag);
        for (int i = 1; i <= N + d; i++) cyc(1'b0, 1'b1, 1'b0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   d;
        int   distinct;
        logic [63:0] seen;

        rst_n = 1'b1; en = 1'b0; trigger = 1'b0; abort = 1'b0;
        #1 rst_n = 1'b0;

        // ---- Reset state ----
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.data",       32'(data_out),   32'd0);
        check_eq("rst.cmd_seq",    32'(cmd_seq),    32'd0);
        check_eq("rst.cmd_delay",  32'(cmd_delay),  32'd0);
        check_eq("rst.lights_out", 32'(lights_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(2);
        cyc(1'b0, 1'b1, 1'b0, "idle0");
        cyc(1'b0, 1'b1, 1'b0, "idle0");

        // ---- 1: basic run ----
        do_run("t1");
        push_idle(2);
        cyc(1'b0, 1'b1, 1'b0, "t1_post");
        cyc(1'b0, 1'b1, 1'b0, "t1_post");

        // ---- 2: async reset while fully lit in HOLD ----
        d = cur_d(N);
        for (int i = 0; i <= N; i++) sbq.push_back(run_rec(i, d));
        cyc(1'b1, 1'b1, 1'b0, "t2");
        for (int i = 1; i <= N; i++) cyc(1'b0, 1'b1, 1'b0, "t2");
        #2 rst_n = 1'b0;
        #1;
        check_eq("t2.async_data",  32'(data_out),   32'd0);
        check_eq("t2.async_seq",   32'(cmd_seq),    32'd0);
        check_eq("t2.async_delay", 32'(cmd_delay),  32'd0);
        check_eq("t2.async_lo",    32'(lights_out), 32'd0);
        @(posedge clk);
        #1;
        check_eq("t2.rst_lo", 32'(lights_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(2);
        cyc(1'b0, 1'b1, 1'b0, "t2_post");
        cyc(1'b0, 1'b1, 1'b0, "t2_post");

        // ---- 3: en low freezes at 03, new rise ignored, then resume ----
        sbq.push_back(run_rec(0, HM));
        sbq.push_back(run_rec(1, HM));
        cyc(1'b1, 1'b1, 1'b0, "t3");
        cyc(1'b0, 1'b1, 1'b0, "t3");
        for (int k = 0; k < 20; k++) begin
            sbq.push_back(run_rec(1, HM));
            cyc((k >= 10), 1'b0, 1'b0, "t3_freeze");
        end
        d = cur_d(N - 2);
        for (int i = 2; i <= N + d; i++) sbq.push_back(run_rec(i, d));
        for (int i = 2; i <= N + d; i++) cyc(1'b1, 1'b1, 1'b0, "t3_resume");
        push_idle(3);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, "t3_post");

        // ---- 4: abort at 0F, then abort beats a simultaneous rise ----
        for (int i = 0; i < 4; i++) sbq.push_back(run_rec(i, HM));
        cyc(1'b1, 1'b1, 1'b0, "t4");
        for (int i = 1; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, "t4");
        push_idle(13);
        cyc(1'b0, 1'b1, 1'b1, "t4_abort");
        for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, 1'b0, "t4_post");
        push_idle(3);
        cyc(1'b1, 1'b1, 1'b1, "t4_abort_rise");
        cyc(1'b1, 1'b1, 1'b0, "t4_held");
        cyc(1'b0, 1'b1, 1'b0, "t4_held");

        // ---- 5: trigger held high for 50 cycles gives one run ----
        d = cur_d(N);
        for (int i = 0; i <= N + d; i++) sbq.push_back(run_rec(i, d));
        push_idle(50 - (N + d + 1));
        for (int k = 0; k < 50; k++) cyc(1'b1, 1'b1, 1'b0, "t5_held");
        push_idle(1);
        cyc(1'b0, 1'b1, 1'b0, "t5_low");
        // Back-to-back: the second rise arrives in the lights_out cycle.
        do_run("t5_run1");
        do_run("t5_run2");
        push_idle(2);
        cyc(1'b0, 1'b1, 1'b0, "t5_post");
        cyc(1'b0, 1'b1, 1'b0, "t5_post");

`ifdef RANDOM_DELAY_EN
        // ---- 6: randomised hold lengths ----
        seen = '0;
        for (int r = 0; r < 20; r++) begin
            d = cur_d(N);
            seen[d] = 1'b1;
            do_run("t6_run");
            push_idle(1);
            cyc(1'b0, 1'b1, 1'b0, "t6_gap");
        end
        distinct = 0;
        for (int k = 0; k < 64; k++) if (seen[k]) distinct++;
        check_eq("t6.distinct_ge3", 32'(distinct >= 3), 32'd1);
`else
        seen = '0;
        distinct = 0;
`endif

        check_eq("sb_drain", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
